// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions for the PHT access controller.
// Holds the 2-bit counter encodings, the saturating counter update and the
// controller state encoding.
package bp_pkg;

  localparam logic [1:0] STRONG_NT = 2'b00;
  localparam logic [1:0] WEAK_NT   = 2'b01;
  localparam logic [1:0] WEAK_T    = 2'b10;
  localparam logic [1:0] STRONG_T  = 2'b11;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } pht_state_e;

  // Saturating 2-bit counter step towards the resolved outcome.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) begin
      return (ctr == STRONG_T) ? STRONG_T : ctr + 2'd1;
    end
    return (ctr == STRONG_NT) ? STRONG_NT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// Synchronous FIFO buffering resolved-branch counter updates.
// Ports: clk, rst (sync, active-high) | push, push_data | pop, pop_data
// (head entry, valid while !empty) | full, empty, count (occupancy).
module bp_upd_fifo #(
  parameter int unsigned WIDTH = 13,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = store[rd_ptr];

  // Power-of-two depth: pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pht_access_ctrl.sv
// Access controller for a single-port 2-bit-counter PHT SRAM.
// Runs the post-reset initialisation sweep, then arbitrates one SRAM access
// per cycle between fetch lookups and queued counter updates.
// Ports:
//   clk, rst                      clock, sync active-high reset
//   lkp_valid/idx/ready           lookup request handshake
//   lkp_rvalid/ctr/taken          lookup result, one cycle after acceptance
//   upd_valid/idx/ctr_old/taken   resolved-branch update request
//   upd_ready                     update accepted into the queue
//   mem_en/we/addr/wdata/rdata    SRAM macro interface
//   init_done                     sweep complete, table usable
module pht_access_ctrl
  import bp_pkg::*;
#(
  parameter int unsigned IDX_W      = 10,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [1:0]  INIT_VAL   = 2'b10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lkp_valid,
  input  logic [IDX_W-1:0] lkp_idx,
  output logic             lkp_ready,
  output logic             lkp_rvalid,
  output logic [1:0]       lkp_ctr,
  output logic             lkp_taken,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic [1:0]       upd_ctr_old,
  input  logic             upd_taken,
  output logic             upd_ready,
  output logic             mem_en,
  output logic             mem_we,
  output logic [IDX_W-1:0] mem_addr,
  output logic [1:0]       mem_wdata,
  input  logic [1:0]       mem_rdata,
  output logic             init_done
);

  localparam int unsigned ENT_W = IDX_W + 3;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  pht_state_e       state;
  logic [IDX_W-1:0] init_cnt;

  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [ENT_W-1:0] fifo_head;
  logic             push;
  logic             pop;
  logic             lkp_go;
  logic             in_run;

  logic [IDX_W-1:0] head_idx;
  logic [1:0]       head_old;
  logic             head_taken;

  // Outputs are gated by rst so nothing reaches the SRAM while reset is held.
  assign in_run    = (state == RUN) && !rst;
  assign init_done = (state == RUN);
  assign lkp_ready = in_run && !fifo_full;
  assign upd_ready = in_run && !fifo_full;
  assign lkp_go    = lkp_valid && lkp_ready;
  assign push      = upd_valid && upd_ready;
  // A full queue blocks lookups, so lkp_go is low and the head drains.
  assign pop       = in_run && !fifo_empty && !lkp_go;

  assign head_idx   = fifo_head[ENT_W-1:3];
  assign head_old   = fifo_head[2:1];
  assign head_taken = fifo_head[0];

  assign lkp_ctr   = mem_rdata;
  assign lkp_taken = lkp_ctr[1];

  bp_upd_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({upd_idx, upd_ctr_old, upd_taken}),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!rst && state == INIT) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = init_cnt;
      mem_wdata = INIT_VAL;
    end else if (lkp_go) begin
      mem_en   = 1'b1;
      mem_addr = lkp_idx;
    end else if (pop) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = head_idx;
      mem_wdata = ctr_next(head_old, head_taken);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= INIT;
      init_cnt   <= '0;
      lkp_rvalid <= 1'b0;
    end else begin
      if (state == INIT) begin
        init_cnt <= init_cnt + 1'b1;
        if (init_cnt == '1) state <= RUN;
      end
      lkp_rvalid <= lkp_go;
    end
  end

  a_fifo_count_consistent : assert property (
    @(posedge clk) disable iff (rst) fifo_empty == (fifo_count == '0)
  );

endmodule

// File: tb/tb_pht_access_ctrl.sv
module tb_pht_access_ctrl;

  localparam int unsigned IDX_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             lkp_valid;
  logic [IDX_W-1:0] lkp_idx;
  logic             lkp_ready;
  logic             lkp_rvalid;
  logic [1:0]       lkp_ctr;
  logic             lkp_taken;
  logic             upd_valid;
  logic [IDX_W-1:0] upd_idx;
  logic [1:0]       upd_ctr_old;
  logic             upd_taken;
  logic             upd_ready;
  logic             mem_en;
  logic             mem_we;
  logic [IDX_W-1:0] mem_addr;
  logic [1:0]       mem_wdata;
  logic [1:0]       mem_rdata;
  logic             init_done;

  int n_checks = 0;
  int n_pass   = 0;

  logic [1:0] sram [16];

  always #5 clk = ~clk;

  pht_access_ctrl #(
    .IDX_W      (IDX_W),
    .FIFO_DEPTH (4),
    .INIT_VAL   (2'b10)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .lkp_valid   (lkp_valid),
    .lkp_idx     (lkp_idx),
    .lkp_ready   (lkp_ready),
    .lkp_rvalid  (lkp_rvalid),
    .lkp_ctr     (lkp_ctr),
    .lkp_taken   (lkp_taken),
    .upd_valid   (upd_valid),
    .upd_idx     (upd_idx),
    .upd_ctr_old (upd_ctr_old),
    .upd_taken   (upd_taken),
    .upd_ready   (upd_ready),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .init_done   (init_done)
  );

  // Single-port SRAM stub: read data appears the cycle after the read.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else        mem_rdata <= sram[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // SRAM access packed as {en, we, addr, wdata}.
  task automatic check_mem(input string tag, input logic en, input logic we,
                           input logic [IDX_W-1:0] addr, input logic [1:0] data);
    check(tag, {mem_en, mem_we, mem_addr, mem_wdata}, {en, we, addr, data});
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Full sweep with requests held high; neither may be accepted.
  task automatic sweep();
    lkp_valid = 1'b1;
    upd_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      check($sformatf("sweep_wr%0d", i), {mem_en, mem_we, mem_addr, mem_wdata},
            {1'b1, 1'b1, 4'(i), 2'b10});
      check($sformatf("sweep_rdy%0d", i), {lkp_ready, upd_ready, init_done}, 3'b000);
      next_cycle();
    end
    lkp_valid = 1'b0;
    upd_valid = 1'b0;
    #1;
    check("init_done", init_done, 1'b1);
    check("post_sweep_idle", mem_en, 1'b0);
    check("post_sweep_ready", {lkp_ready, upd_ready}, 2'b11);
  endtask

  // One update pushed into an empty queue, drained the following idle cycle.
  task automatic upd_drain(input logic [IDX_W-1:0] idx, input logic [1:0] old,
                           input logic taken, input logic [1:0] exp);
    lkp_valid   = 1'b0;
    upd_valid   = 1'b1;
    upd_idx     = idx;
    upd_ctr_old = old;
    upd_taken   = taken;
    #1;
    check("upd_ready", upd_ready, 1'b1);
    check("push_cycle_idle", mem_en, 1'b0);
    next_cycle();
    upd_valid = 1'b0;
    #1;
    check_mem($sformatf("drain_idx%0d", idx), 1'b1, 1'b1, idx, exp);
    next_cycle();
  endtask

  logic [IDX_W-1:0] bp_idx [4] = '{4'd1, 4'd2, 4'd3, 4'd4};
  logic [1:0]       bp_old [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  logic             bp_tkn [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic [1:0]       bp_exp [4] = '{2'b01, 2'b00, 2'b10, 2'b11};

  initial begin
    rst = 1'b1;
    lkp_valid = 1'b0; lkp_idx = '0;
    upd_valid = 1'b0; upd_idx = '0; upd_ctr_old = '0; upd_taken = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_mem_en", mem_en, 1'b0);
    check("rst_flags", {init_done, lkp_rvalid, lkp_ready, upd_ready}, 4'b0000);
    rst = 1'b0;
    sweep();
    check("sram15_init", sram[15], 2'b10);
    next_cycle();

    // Lookup latency
    upd_drain(4'd5, 2'b10, 1'b1, 2'b11);
    #1;
    check("idle_after_drain", mem_en, 1'b0);
    lkp_valid = 1'b1;
    lkp_idx   = 4'd5;
    #1;
    check("lkp_ready", lkp_ready, 1'b1);
    check_mem("lkp_read", 1'b1, 1'b0, 4'd5, 2'b00);
    next_cycle();
    lkp_valid = 1'b0;
    #1;
    check("lkp_result", {lkp_rvalid, lkp_ctr, lkp_taken}, 4'b1111);
    next_cycle();
    #1;
    check("rvalid_drop", lkp_rvalid, 1'b0);
    next_cycle();

    // Saturation and normal steps
    upd_drain(4'd6, 2'b11, 1'b1, 2'b11);
    upd_drain(4'd7, 2'b00, 1'b0, 2'b00);
    upd_drain(4'd8, 2'b10, 1'b0, 2'b01);
    upd_drain(4'd9, 2'b01, 1'b1, 2'b10);

    // Back-pressure: lookups every cycle while the queue fills
    lkp_valid = 1'b1;
    lkp_idx   = 4'd5;
    for (int k = 0; k < 4; k++) begin
      upd_valid   = 1'b1;
      upd_idx     = bp_idx[k];
      upd_ctr_old = bp_old[k];
      upd_taken   = bp_tkn[k];
      #1;
      check($sformatf("bp_fill_rdy%0d", k), {upd_ready, lkp_ready}, 2'b11);
      check($sformatf("bp_fill_rd%0d", k), {mem_en, mem_we}, 2'b10);
      next_cycle();
    end
    upd_idx = 4'd10; upd_ctr_old = 2'b00; upd_taken = 1'b1;
    #1;
    check("bp_full_rdy", {upd_ready, lkp_ready}, 2'b00);
    check_mem("bp_full_drain", 1'b1, 1'b1, bp_idx[0], bp_exp[0]);
    next_cycle();
    upd_valid = 1'b0;
    #1;
    check("bp_recover_rdy", {upd_ready, lkp_ready}, 2'b11);
    check("bp_rvalid_after_drain", lkp_rvalid, 1'b0);
    check("bp_recover_rd", {mem_en, mem_we}, 2'b10);
    next_cycle();

    // Idle drain of remaining three in FIFO order
    lkp_valid = 1'b0;
    for (int k = 1; k < 4; k++) begin
      #1;
      if (k == 1) check("rvalid_after_lkp", lkp_rvalid, 1'b1);
      check_mem($sformatf("idle_drain%0d", k), 1'b1, 1'b1, bp_idx[k], bp_exp[k]);
      next_cycle();
    end
    #1;
    check("idle_after_queue", mem_en, 1'b0);
    next_cycle();

    // Reset mid-run with two updates queued behind lookups
    lkp_valid = 1'b1;
    lkp_idx   = 4'd3;
    upd_valid = 1'b1; upd_idx = 4'd11; upd_ctr_old = 2'b00; upd_taken = 1'b1;
    #1;
    check("mr_push0", upd_ready, 1'b1);
    next_cycle();
    upd_idx = 4'd12; upd_ctr_old = 2'b11; upd_taken = 1'b0;
    #1;
    check("mr_push1", upd_ready, 1'b1);
    next_cycle();
    rst = 1'b1;
    lkp_valid = 1'b0;
    upd_valid = 1'b0;
    #1;
    check("mr_rst_mem_en", mem_en, 1'b0);
    next_cycle();
    rst = 1'b0;
    #1;
    check("mr_flags", {init_done, lkp_rvalid}, 2'b00);
    sweep();
    next_cycle();
    #1;
    check("mr_no_stale_drain", mem_en, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/pht_access_ctrl.md
Name: pht_access_ctrl

Overview:
- Controller for a single-port 2-bit-counter pattern history table (PHT) SRAM used by the dynamic branch predictor.
- Sequences the post-reset table initialisation sweep, so no single-cycle reset of the whole table is needed.
- Arbitrates each cycle between fetch-stage prediction lookups and resolved-branch counter updates; updates are buffered in a small FIFO.
- Sits between the predictor index logic (GHR xor PC) and the PHT SRAM macro.

Parameters:
- IDX_W, 10, PHT index width; table holds 2^IDX_W entries.
- FIFO_DEPTH, 4, update queue depth (power of two, >= 2).
- INIT_VAL, 2'b10, counter value written during initialisation (weakly taken).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- lkp_valid  in  1  fetch stage requests a prediction
- lkp_idx  in  IDX_W  PHT index for the lookup
- lkp_ready  out  1  lookup is accepted this cycle
- lkp_rvalid  out  1  lookup result is valid (one cycle after acceptance)
- lkp_ctr  out  2  counter read for the lookup
- lkp_taken  out  1  lkp_ctr[1]
- upd_valid  in  1  resolved branch update request
- upd_idx  in  IDX_W  index captured at prediction time
- upd_ctr_old  in  2  counter value captured at prediction time
- upd_taken  in  1  actual branch outcome
- upd_ready  out  1  update accepted (FIFO not full and init_done)
- mem_en  out  1  SRAM access enable
- mem_we  out  1  SRAM write enable
- mem_addr  out  IDX_W  SRAM address
- mem_wdata  out  2  SRAM write data
- mem_rdata  in  2  SRAM read data; valid the cycle after a read
- init_done  out  1  initialisation sweep complete

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. During rst the block enters INIT and sets init_cnt=0, the FIFO empty, lkp_rvalid=0, init_done=0 and mem_en=0. rst asserted mid-operation discards all queued updates and in-flight reads, then restarts the sweep.
- States: INIT, RUN.
- INIT:
  - Each cycle: mem_en=1, mem_we=1, mem_addr=init_cnt, mem_wdata=INIT_VAL, then init_cnt increments.
  - After the write to address 2^IDX_W-1, the next state is RUN.
  - The sweep takes exactly 2^IDX_W cycles.
  - lkp_ready=0 and upd_ready=0 throughout INIT.
- RUN: init_done=1, which stays asserted until the next rst.
- Arbitration priority in RUN, one SRAM access per cycle:
  - (1) FIFO full: drain the head entry. lkp_ready=0.
  - (2) lkp_valid: read lkp_idx. lkp_ready=1.
  - (3) FIFO non-empty: drain the head entry.
  - (4) Otherwise idle, mem_en=0.
- lkp_ready is combinational: init_done and not FIFO-full.
- Drain: single write to the entry's index. No read-modify-write.
  - new = sat_inc(old) if taken, else sat_dec(old).
  - 2'b11 saturates on taken; 2'b00 saturates on not-taken. The write occurs even when the value is unchanged.
- Lookup latency:
  - Accepted in cycle N; lkp_rvalid=1 in N+1, with lkp_ctr=mem_rdata.
  - lkp_rvalid=0 in any cycle following a non-lookup cycle.
- FIFO:
  - Push when upd_valid and upd_ready.
  - No same-cycle bypass when full: upd_ready is low while full, even in a cycle that drains.
  - Push and pop in the same cycle are allowed when not full; occupancy is then unchanged.
  - Pointers wrap modulo FIFO_DEPTH. The count is log2(FIFO_DEPTH)+1 bits wide.
- No RAW forwarding: a lookup to an index with a pending queued update returns the stale SRAM value. This is accepted predictor inaccuracy, not an error.
- Upd_valid while upd_ready=0: the request is not taken. The requester holds it.

Decomposition:
- Shared package bp_pkg:
  - counter encodings STRONG_NT=2'b00, WEAK_NT=2'b01, WEAK_T=2'b10, STRONG_T=2'b11
  - function ctr_next(ctr, taken) implementing the saturating update
  - state enum {INIT, RUN}
- One sub-module, bp_upd_fifo: parameterised sync FIFO (width IDX_W+3, depth FIFO_DEPTH) with full/empty/count outputs.

Test Plan:
- Init sweep (IDX_W=4): release rst. Expect 16 consecutive writes of 2'b10 to addresses 0..15, then init_done=1 in cycle 17. Expect lkp_ready=0 and upd_ready=0 throughout the sweep.
- Lookup latency: write 2'b11 to idx 5 via an update, drain it, then lookup idx 5. Expect lkp_rvalid=1, lkp_ctr=2'b11 and lkp_taken=1 exactly one cycle later.
- Saturation: update (old=2'b11, taken=1) writes 2'b11; (old=2'b00, taken=0) writes 2'b00; (old=2'b10, taken=0) writes 2'b01; (old=2'b01, taken=1) writes 2'b10.
- Back-pressure:
  - Hold lkp_valid=1 every cycle and push 4 updates. The FIFO fills and upd_ready drops.
  - Next cycle: lkp_ready=0 and one drain write occurs; the cycle after, upd_ready=1 again.
- Idle drain: 3 queued updates with lkp_valid=0. Expect 3 writes on 3 consecutive cycles in FIFO order, then mem_en=0.
- Reset mid-run: 2 updates queued, assert rst for 1 cycle. The FIFO empties, no queued writes are issued, and the INIT sweep restarts from address 0.
